mm_stream_param: RTL and testbench
==================================

// Module: mm_stream_param
// PURPOSE
//  Parametrised streaming signed matrix multiplier: C = A x B, with A and B up to MAXD x MAXD.
//  Receives A and then B row-major over one element-per-beat input stream.
//  Checks legality, then streams out C row-major with row markers.
//  Successor to the fixed 4x4 / 8-bit multiplier; adds an input handshake, parametrised sizes,
//  dimension-overflow detection, optional saturation and an end-of-matrix flag.
// PARAMETERS
//  DW    8   input element width, two's complement
//  MAXD  4   maximum rows/cols per operand (>=2)
//  OW    20  out_data width
//  SAT   0   1: clamp result to OW signed range; 0: truncate to low OW bits
// PORTS
//  clk         in   1    rising-edge clock
//  rst         in   1    asynchronous, active-low reset
//  in_valid    in   1    in_data/col_end/row_end valid this cycle
//  in_data     in   DW   matrix element (signed)
//  col_end     in   1    element is last of its row
//  row_end     in   1    with col_end: element is last of the matrix
//  busy        out  1    1 = input not accepted (beat accepted iff in_valid && !busy)
//  valid       out  1    output beat strobe (one cycle per beat)
//  out_data    out  OW   C element (signed); 0 on illegal beat
//  is_legal    out  1    qualified by valid
//  change_row  out  1    qualified by valid; beat is last element of a C row
//  mat_end     out  1    qualified by valid; last beat of this result
// BEHAVIOUR
//  Reset (rst=0, async): state RD_A, all counters/flags cleared.
//   busy=0, valid=0, out_data=0, is_legal=0, change_row=0, mat_end=0.
//   Reset mid-operation discards all partial data.
//  FSM: RD_A -> RD_B -> (MAC <-> OUT) -> RD_A; an illegal pair goes RD_B -> OUT(1 beat) -> RD_A.
//  RD_A/RD_B, busy=0:
//   Accepted beats are stored at [r][c]; c increments per beat.
//   col_end: records the row length (first row) or compares against it (later rows); r++, c=0.
//   col_end&&row_end: ends the operand; next operand/state on the following cycle.
//   The first element of B is accepted at the earliest in the cycle after A's last element.
//  Illegality flags (sticky until end of the pair); the pair is illegal if any is set:
//   (a) ragged rows within A or within B
//   (b) more than MAXD columns or rows in either operand; overflow elements are dropped
//       and the stream is still consumed to its end marker
//   (c) colsA != rowsB
//  busy: 1 from the cycle after B's last element through the cycle of the final OUT beat; 0 after.
//  MAC: one signed DWxDW product per cycle into a 2*DW+clog2(MAXD)+1-bit accumulator.
//   K = colsA cycles per C element; the accumulator is cleared on entry.
//  OUT: one cycle, valid=1, is_legal=1.
//   out_data = acc (SAT=0: low OW bits; SAT=1: clamped to [-2^(OW-1), 2^(OW-1)-1]).
//   change_row=1 when j==colsB-1; mat_end=1 on element (rowsA-1, colsB-1).
//   Then back to MAC, or to RD_A after the last element.
//  Illegal pair: a single beat valid=1, is_legal=0, out_data=0, change_row=0, mat_end=1.
//  Output timing:
//   - Legal C element latency is K+1 cycles per element; total busy time = rowsA*colsB*(K+1).
//   - valid=0 in every non-OUT cycle; out_data holds its last value.
//  After the last beat, state is RD_A with counters cleared; no dead cycle before the next A.
//  in_valid=0 beats are ignored, with no counter change; gaps are allowed anywhere in input.
//  Inputs while busy=1 are ignored.
// TESTING
//  1. A=2x3[1 2 3;4 5 6], B=3x2[7 8;9 10;11 12] -> beats 58,64(cr),139,154(cr,end), all legal.
//  2. A=1x1[-128], B=1x1[-128] -> one beat 16384, cr=1, mat_end=1; busy high exactly 2 cycles.
//  3. A=2x2, B=3x1 -> single beat is_legal=0, out_data=0, mat_end=1; next pair accepted immediately.
//  4. A rows of 3 then 2 elements (ragged), B valid -> illegal beat.
//     Also A with 5 columns at MAXD=4 -> illegal beat.
//  5. SAT=1, OW=16, A=1x4 all -128, B=4x1 all -128 -> out_data=32767.
//     Same case with SAT=0 -> out_data=0 (65536 truncated).
//  6. Case 1 with random in_valid gaps and rst pulsed mid-MAC -> gaps leave results unchanged.
//     rst pulse: outputs go to 0 asynchronously; the following pair computes correctly.

Source files
------------

// File: rtl/mm_stream_param.sv
`default_nettype none
// ============================================================================
// Module   : mm_stream_param
// Purpose  : Streaming signed matrix multiplier C = A x B (operands up to
//            MAXD x MAXD). Elements of A and then B arrive row-major, one per
//            beat. Each pair is checked for legality (ragged rows, size
//            overflow, colsA != rowsB). C is then emitted row-major, one
//            element per K+1 cycles. An illegal pair produces one beat with
//            is_legal=0.
// Ports    : clk        rising-edge clock
//            rst        asynchronous active-low reset
//            in_valid   input beat valid (accepted iff in_valid && !busy)
//            in_data    signed element, DW bits
//            col_end    element is last of its row
//            row_end    with col_end: element is last of the operand
//            busy       input not accepted
//            valid      output beat strobe
//            out_data   C element (SAT ? clamped : truncated), OW bits
//            is_legal   pair legality, qualified by valid
//            change_row last element of a C row, qualified by valid
//            mat_end    last beat of this result, qualified by valid
// Revision : 1.0  initial release
// ============================================================================
module mm_stream_param #(
  parameter int DW   = 8,
  parameter int MAXD = 4,
  parameter int OW   = 20,
  parameter int SAT  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          col_end,
  input  logic          row_end,
  output logic          busy,
  output logic          valid,
  output logic [OW-1:0] out_data,
  output logic          is_legal,
  output logic          change_row,
  output logic          mat_end
);

  localparam int c_iw = $clog2(MAXD);
  // One extra bit so row/column counts can saturate at MAXD+1 (overflow).
  localparam int c_cw = c_iw + 1;
  localparam int c_aw = 2*DW + $clog2(MAXD) + 1;
  localparam int c_ww = ((c_aw > OW) ? c_aw : OW) + 1;
  localparam logic [c_cw-1:0]        c_one  = c_cw'(1);
  localparam logic [c_cw-1:0]        c_maxd = c_cw'(MAXD);
  localparam logic signed [c_ww-1:0] c_max  = {{(c_ww-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [c_ww-1:0] c_min  = {{(c_ww-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {
    RD_A = 2'd0,
    RD_B = 2'd1,
    MAC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic signed [DW-1:0]   a_q [MAXD][MAXD];
  logic signed [DW-1:0]   a_d [MAXD][MAXD];
  logic signed [DW-1:0]   b_q [MAXD][MAXD];
  logic signed [DW-1:0]   b_d [MAXD][MAXD];
  logic [c_cw-1:0]        r_q, r_d, c_q, c_d, len_q, len_d;
  logic [c_cw-1:0]        cols_a_q, cols_a_d, rows_a_q, rows_a_d, cols_b_q, cols_b_d;
  logic                   err_q, err_d;
  logic [c_iw-1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
  logic signed [c_aw-1:0] acc_q, acc_d;
  logic                   valid_q, valid_d, legal_q, legal_d, cr_q, cr_d, me_q, me_d;
  logic [OW-1:0]          out_q, out_d;

  logic                   w_accept, w_in_range, w_k_last, w_j_last, w_i_last;
  logic [c_cw-1:0]        w_c_inc, w_r_inc, w_row_len;
  logic signed [2*DW-1:0] w_prod;

  // Sign-extend the accumulator, optionally clamp, then keep the low OW bits.
  function automatic logic [OW-1:0] f_fit(input logic signed [c_aw-1:0] v);
    logic signed [c_ww-1:0] ext;
    ext = {{(c_ww-c_aw){v[c_aw-1]}}, v};
    if (SAT != 0) begin
      if (ext > c_max)      ext = c_max;
      else if (ext < c_min) ext = c_min;
    end
    return ext[OW-1:0];
  endfunction

  assign busy       = (state_q == MAC) || (state_q == OUT);
  assign valid      = valid_q;
  assign out_data   = out_q;
  assign is_legal   = legal_q;
  assign change_row = cr_q;
  assign mat_end    = me_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    c_d      = c_q;
    len_d    = len_q;
    cols_a_d = cols_a_q;
    rows_a_d = rows_a_q;
    cols_b_d = cols_b_q;
    err_d    = err_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    valid_d  = 1'b0;
    legal_d  = legal_q;
    cr_d     = cr_q;
    me_d     = me_q;
    out_d    = out_q;

    w_accept   = in_valid && !busy;
    w_in_range = (c_q < c_maxd) && (r_q < c_maxd);
    w_c_inc    = (c_q > c_maxd) ? c_q : c_q + c_one;
    w_r_inc    = (r_q > c_maxd) ? r_q : r_q + c_one;
    // The first row defines the operand's width; later rows only compare.
    w_row_len  = (r_q == '0) ? w_c_inc : len_q;
    w_k_last   = ({1'b0, k_q} == cols_a_q - c_one);
    w_j_last   = ({1'b0, j_q} == cols_b_q - c_one);
    w_i_last   = ({1'b0, i_q} == rows_a_q - c_one);
    w_prod     = a_q[i_q][k_q] * b_q[k_q][j_q];

    case (state_q)
      RD_A, RD_B: begin
        if (w_accept) begin
          // Out-of-range elements are dropped but the stream is still consumed.
          if (w_in_range) begin
            if (state_q == RD_A) a_d[r_q[c_iw-1:0]][c_q[c_iw-1:0]] = in_data;
            else                 b_d[r_q[c_iw-1:0]][c_q[c_iw-1:0]] = in_data;
          end else begin
            err_d = 1'b1;
          end
          if (col_end) begin
            if (r_q == '0)              len_d = w_c_inc;
            else if (w_c_inc != len_q)  err_d = 1'b1;
            c_d = '0;
            r_d = w_r_inc;
            if (row_end) begin
              r_d   = '0;
              len_d = '0;
              if (state_q == RD_A) begin
                cols_a_d = w_row_len;
                rows_a_d = w_r_inc;
                state_d  = RD_B;
              end else begin
                cols_b_d = w_row_len;
                if (err_d || (cols_a_q != w_r_inc)) begin
                  state_d = OUT;
                  valid_d = 1'b1;
                  legal_d = 1'b0;
                  out_d   = '0;
                  cr_d    = 1'b0;
                  me_d    = 1'b1;
                end else begin
                  state_d = MAC;
                end
                err_d = 1'b0;
              end
            end
          end else begin
            c_d = w_c_inc;
          end
        end
      end
      MAC: begin
        // k==0 restarts the accumulator, so each C element starts from zero.
        acc_d = ((k_q == '0) ? '0 : acc_q) + {{(c_aw-2*DW){w_prod[2*DW-1]}}, w_prod};
        if (w_k_last) begin
          k_d     = '0;
          state_d = OUT;
          valid_d = 1'b1;
          legal_d = 1'b1;
          out_d   = f_fit(acc_d);
          cr_d    = w_j_last;
          me_d    = w_j_last && w_i_last;
        end else begin
          k_d = k_q + c_iw'(1);
        end
      end
      OUT: begin
        if (me_q) begin
          state_d = RD_A;
          i_d     = '0;
          j_d     = '0;
        end else begin
          state_d = MAC;
          if (cr_q) begin
            j_d = '0;
            i_d = i_q + c_iw'(1);
          end else begin
            j_d = j_q + c_iw'(1);
          end
        end
      end
      default: state_d = RD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RD_A;
      for (int r = 0; r < MAXD; r++) begin
        for (int c = 0; c < MAXD; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
      r_q      <= '0;
      c_q      <= '0;
      len_q    <= '0;
      cols_a_q <= '0;
      rows_a_q <= '0;
      cols_b_q <= '0;
      err_q    <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      legal_q  <= 1'b0;
      cr_q     <= 1'b0;
      me_q     <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      c_q      <= c_d;
      len_q    <= len_d;
      cols_a_q <= cols_a_d;
      rows_a_q <= rows_a_d;
      cols_b_q <= cols_b_d;
      err_q    <= err_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      valid_q  <= valid_d;
      legal_q  <= legal_d;
      cr_q     <= cr_d;
      me_q     <= me_d;
      out_q    <= out_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mm_stream_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_stream_param
// Purpose  : Scoreboard bench for mm_stream_param. Three instances share one
//            input stream: (OW=20,SAT=0), (OW=16,SAT=1), (OW=16,SAT=0).
//            Expected beats come from a matrix-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mm_stream_param;
  localparam int MAXD = 4;

  typedef struct {
    longint d;
    bit     lg;
    bit     cr;
    bit     me;
    int     bsy;
  } exp_t;

  logic        clk, rst, in_valid, col_end, row_end;
  logic [7:0]  in_data;
  logic [2:0]  bz, vl, lg, cr, me;
  logic [19:0] od0;
  logic [15:0] od1, od2;

  int   checks, failures, bcnt;
  exp_t q0[$], q1[$], q2[$];
  int   a_rows, b_rows;
  int   a_len[8], b_len[8];
  int   a_v[8][8], b_v[8][8];
  bit   gaps_en;

  mm_stream_param #(.DW(8), .MAXD(MAXD), .OW(20), .SAT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .col_end(col_end),
    .row_end(row_end), .busy(bz[0]), .valid(vl[0]), .out_data(od0), .is_legal(lg[0]),
    .change_row(cr[0]), .mat_end(me[0]));
  mm_stream_param #(.DW(8), .MAXD(MAXD), .OW(16), .SAT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .col_end(col_end),
    .row_end(row_end), .busy(bz[1]), .valid(vl[1]), .out_data(od1), .is_legal(lg[1]),
    .change_row(cr[1]), .mat_end(me[1]));
  mm_stream_param #(.DW(8), .MAXD(MAXD), .OW(16), .SAT(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .col_end(col_end),
    .row_end(row_end), .busy(bz[2]), .valid(vl[2]), .out_data(od2), .is_legal(lg[2]),
    .change_row(cr[2]), .mat_end(me[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int id, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0d exp=%0d", nm, id, got, exp);
    end
  endtask

  // Reference model: whole-matrix legality and product, pushed per instance.
  function automatic void model_push();
    bit     ok;
    longint s, c;
    exp_t   e;
    ok = (a_rows <= MAXD) && (b_rows <= MAXD) && (a_len[0] == b_rows);
    for (int r = 0; r < a_rows; r++) if (a_len[r] != a_len[0] || a_len[r] > MAXD) ok = 0;
    for (int r = 0; r < b_rows; r++) if (b_len[r] != b_len[0] || b_len[r] > MAXD) ok = 0;
    if (!ok) begin
      e.d = 0; e.lg = 0; e.cr = 0; e.me = 1; e.bsy = 1;
      q0.push_back(e); q1.push_back(e); q2.push_back(e);
      return;
    end
    for (int i = 0; i < a_rows; i++) begin
      for (int j = 0; j < b_len[0]; j++) begin
        s = 0;
        for (int k = 0; k < a_len[0]; k++) s += longint'(a_v[i][k]) * longint'(b_v[k][j]);
        e.lg  = 1;
        e.cr  = (j == b_len[0] - 1);
        e.me  = e.cr && (i == a_rows - 1);
        e.bsy = a_rows * b_len[0] * (a_len[0] + 1);
        e.d = s & 64'hFFFFF;
        q0.push_back(e);
        c = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
        e.d = c & 64'hFFFF;
        q1.push_back(e);
        e.d = s & 64'hFFFF;
        q2.push_back(e);
      end
    end
  endfunction

  task automatic chk(input int id, input bit v, input longint d, input bit l, input bit c, input bit m);
    exp_t e;
    bit   have;
    if (!v) return;
    have = 1;
    case (id)
      0:       if (q0.size() == 0) have = 0; else e = q0.pop_front();
      1:       if (q1.size() == 0) have = 0; else e = q1.pop_front();
      default: if (q2.size() == 0) have = 0; else e = q2.pop_front();
    endcase
    if (!have) begin
      checks++;
      failures++;
      $display("FAIL unexpected_beat dut%0d got=%0d exp=none", id, d);
      return;
    end
    check("out_data", id, d, e.d);
    check("is_legal", id, l, e.lg);
    check("change_row", id, c, e.cr);
    check("mat_end", id, m, e.me);
    if (id == 0 && e.me) begin
      check("busy_cycles", id, bcnt, e.bsy);
      bcnt = 0;
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (bz[0]) bcnt++;
      chk(0, vl[0], longint'(od0), lg[0], cr[0], me[0]);
      chk(1, vl[1], longint'(od1), lg[1], cr[1], me[1]);
      chk(2, vl[2], longint'(od2), lg[2], cr[2], me[2]);
    end
  end

  task automatic drive_beat(input int v, input bit ce, input bit re);
    int g, guard;
    g = 0;
    if (gaps_en && $urandom_range(0, 2) == 0) g = $urandom_range(1, 3);
    repeat (g) @(negedge clk);
    in_valid = 1'b1;
    in_data  = v[7:0];
    col_end  = ce;
    row_end  = re;
    guard = 0;
    while (bz[0]) begin
      @(negedge clk);
      guard++;
      if (guard > 300) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout dut0 got=busy exp=idle");
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    col_end  = 1'b0;
    row_end  = 1'b0;
  endtask

  task automatic send_operand(input bit is_b);
    int rows, len, v;
    rows = is_b ? b_rows : a_rows;
    for (int r = 0; r < rows; r++) begin
      len = is_b ? b_len[r] : a_len[r];
      for (int c = 0; c < len; c++) begin
        v = is_b ? b_v[r][c] : a_v[r][c];
        drive_beat(v, c == len - 1, (c == len - 1) && (r == rows - 1));
      end
    end
  endtask

  task automatic send_pair();
    model_push();
    send_operand(0);
    send_operand(1);
  endtask

  task automatic fill_rand(input bit is_b, input int rows, input int cols);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (is_b) b_v[r][c] = int'($urandom_range(0, 255)) - 128;
        else      a_v[r][c] = int'($urandom_range(0, 255)) - 128;
      end
      if (is_b) b_len[r] = cols; else a_len[r] = cols;
    end
    if (is_b) b_rows = rows; else a_rows = rows;
  endtask

  task automatic load_case1();
    fill_rand(0, 2, 3);
    fill_rand(1, 3, 2);
    for (int r = 0; r < 2; r++) for (int c = 0; c < 3; c++) a_v[r][c] = r * 3 + c + 1;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 2; c++) b_v[r][c] = r * 2 + c + 7;
  endtask

  task automatic rand_pair();
    int m, ra, ca, cb, rb;
    m  = $urandom_range(0, 9);
    ra = $urandom_range(1, MAXD);
    ca = $urandom_range(1, MAXD);
    cb = $urandom_range(1, MAXD);
    rb = ca;
    case (m)
      0: if (ra < 2) ra = 2;
      1: begin if (ca < 2) ca = 2; rb = ca; end
      2: begin ca = MAXD + 1; rb = ca; end
      3: ra = MAXD + 1;
      4: rb = (ca == MAXD) ? ca - 1 : ca + 1;
      default: ;
    endcase
    fill_rand(0, ra, ca);
    fill_rand(1, rb, cb);
    if (m == 0) a_len[ra-1] = (ca == MAXD) ? ca - 1 : ca + 1;
    if (m == 1) b_len[rb-1] = (cb == MAXD) ? cb - 1 : cb + 1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (q0.size() + q1.size() + q2.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout dut0 got=%0d exp=0 pending", q0.size());
    end
  endtask

  initial begin
    checks = 0; failures = 0; bcnt = 0; gaps_en = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; col_end = 1'b0; row_end = 1'b0;
    #2 rst = 1'b0;
    #2;
    check("rst_busy", 0, bz[0], 0);
    check("rst_valid", 0, vl[0], 0);
    check("rst_out_data", 0, od0, 0);
    check("rst_is_legal", 0, lg[0], 0);
    check("rst_change_row", 0, cr[0], 0);
    check("rst_mat_end", 0, me[0], 0);
    check("rst_out_data", 1, od1, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // 2x3 by 3x2 -> 58 64 / 139 154
    load_case1();
    send_pair();
    // 1x1 extremes: -128 * -128
    fill_rand(0, 1, 1); fill_rand(1, 1, 1);
    a_v[0][0] = -128; b_v[0][0] = -128;
    send_pair();
    // Inner-dimension mismatch, then a legal pair straight after
    fill_rand(0, 2, 2); fill_rand(1, 3, 1);
    send_pair();
    load_case1();
    send_pair();
    // Ragged A (3 then 2)
    load_case1();
    a_len[1] = 2;
    send_pair();
    // Five columns in A at MAXD=4
    fill_rand(0, 2, 5); fill_rand(1, 5, 1);
    send_pair();
    // Saturation / truncation: 4 * 16384 = 65536
    fill_rand(0, 1, 4); fill_rand(1, 4, 1);
    for (int k = 0; k < 4; k++) begin a_v[0][k] = -128; b_v[k][0] = -128; end
    send_pair();
    // Case 1 with random input gaps
    gaps_en = 1;
    load_case1();
    send_pair();
    gaps_en = 0;
    wait_idle();

    // Reset pulsed mid-MAC discards the pair; the next pair still computes.
    load_case1();
    send_pair();
    @(negedge clk);
    check("busy_mid_mac", 0, bz[0], 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy", 0, bz[0], 0);
    check("async_rst_valid", 0, vl[0], 0);
    check("async_rst_out_data", 0, od0, 0);
    check("async_rst_out_data", 1, od1, 0);
    q0.delete(); q1.delete(); q2.delete();
    bcnt = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    load_case1();
    send_pair();

    for (int n = 0; n < 40; n++) begin
      gaps_en = $urandom_range(0, 1) == 1;
      rand_pair();
      send_pair();
    end
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
